param_bitmask_mem: RTL and testbench
====================================

Name: param_bitmask_mem

Overview:
Parametrised single-port bit-masked memory, the successor to the fixed 8x32 bit-masked memory. Width, depth, read latency and initialisation value are configurable. Adds a hardware clear sweep on reset and on request, a busy indication, an aligned read-valid strobe and an error strobe. It serves as the generic masked register-file/scratch store for the datapath blocks.

Parameters:
DATA_W, 32, data, mask and read-data width in bits (>=1)
DEPTH, 8, number of words (>=2; need not be a power of two)
ADDR_W, $clog2(DEPTH), address width (derived; do not override)
RD_LAT, 1, read latency in cycles; legal values 1 or 2
INIT_VAL, 0, DATA_W-bit value written to every word by a clear sweep

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
enb  input  1  access enable; an access is requested this cycle
wr  input  1  1 = masked write, 0 = read (qualified by enb)
addr  input  ADDR_W  word address
data  input  DATA_W  write data
masked  input  DATA_W  write mask; bit=1 means that bit is written
clr  input  1  single-cycle request to start a clear sweep
busy  output  1  clear sweep in progress; accesses are refused
r_data  output  DATA_W  read data
r_valid  output  1  one-cycle strobe, aligned with new r_data
err  output  1  one-cycle strobe: access refused or out of range

Behaviour:
- Reset: while rst_n=0, FSM=SWEEP, sweep pointer=0, busy=1, r_data=0, r_valid=0, err=0, and the read pipeline is flushed. Memory array is not reset directly.
- FSM states: SWEEP and IDLE.
- SWEEP: each cycle, mem[ptr] <= INIT_VAL and ptr increments. On the cycle writing ptr=DEPTH-1, the next state is IDLE.
- Sweep timing: busy=1 for exactly DEPTH rising edges after rst_n deasserts. busy=0 from the following cycle.
- IDLE with clr=1: next state is SWEEP with ptr=0. busy=1 from the next cycle for DEPTH cycles. clr takes priority over a same-cycle access; that access is refused (err).
- clr while busy is ignored, with no restart and no err.
- rst_n asserted mid-sweep restarts the sweep from ptr 0 after release.
- Masked write (IDLE, enb=1, wr=1, addr<DEPTH): at the clock edge, mem[addr] <= (mem[addr] & ~masked) | (data & masked).
  - masked=0 leaves the word unchanged.
  - A read of the same address in the next cycle returns the updated word (no stale data).
- Read (IDLE, enb=1, wr=0, addr<DEPTH):
  - r_data = mem[addr] and r_valid=1 exactly RD_LAT cycles after the request edge.
  - Back-to-back reads are fully pipelined: one result per cycle.
  - r_data holds its last value when r_valid=0.
- Out of range (addr>=DEPTH, only possible when DEPTH is not a power of two):
  - Write: ignored, err=1 the next cycle.
  - Read: returns 0 with r_valid=1 at normal latency, plus err=1 the next cycle.
- Access while busy (enb=1): dropped with no memory change and no r_valid. err=1 the next cycle.
- enb=0: wr, addr, data and masked are don't-care; no effect.
- err is registered, latency 1, independent of RD_LAT.
- Reads already in the RD_LAT pipeline when a sweep starts still complete and return the pre-sweep value.

Test Plan:
1. DATA_W=32, DEPTH=8, RD_LAT=1, INIT_VAL=0; release rst_n -> busy=1 for 8 edges then 0; read addr 0..7 back-to-back -> 8 consecutive r_valid cycles, r_data=0 each, first valid 1 cycle after the first request.
2. Write addr=3, data=0x0000003F, masked=0x000003FF -> read addr 3 next cycle returns 0x0000003F. Then write data=0xFFFFFF87, masked=0xFFE003FF -> read returns 0xFFE00387.
3. Write addr=3, data=0xFFFFFFFF, masked=0 -> addr 3 unchanged at 0xFFE00387. Write addr=7 with random data/mask -> read matches the (old&~m)|(d&m) model.
4. RD_LAT=2 instance: read addrs 0..7 back-to-back -> r_valid high 8 consecutive cycles, starting 2 cycles after the first request, data in address order.
5. Fill all words with 0xA5A5A5A5; pulse clr (INIT_VAL=0x12345678 instance) -> busy for 8 cycles. A write during busy -> err pulse and data unchanged. A second clr during busy -> ignored. After the sweep, all reads return 0x12345678.
6. DEPTH=6: write/read addr 7 -> write ignored, read returns 0 with r_valid and err. Assert rst_n at sweep ptr=3 -> after release busy lasts the full 6 cycles.

Source files
------------

// File: rtl/param_bitmask_mem_if.sv
// Access bus for param_bitmask_mem: request/write side plus read/status return.
interface param_bitmask_mem_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 3
);
   logic              enb;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] data;
   logic [DATA_W-1:0] masked;
   logic              clr;
   logic              busy;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              err;

   modport master (
      output enb, wr, addr, data, masked, clr,
      input  busy, r_data, r_valid, err
   );

   modport slave (
      input  enb, wr, addr, data, masked, clr,
      output busy, r_data, r_valid, err
   );
endinterface

// File: rtl/param_bitmask_mem.sv
// Single-port bit-masked memory with configurable geometry and read latency,
// a hardware clear sweep after reset or on request, and registered status strobes.
module param_bitmask_mem #(
   parameter int                DATA_W   = 32,
   parameter int                DEPTH    = 8,
   parameter int                ADDR_W   = $clog2(DEPTH),
   parameter int                RD_LAT   = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input logic               clk,
   input logic               rst_n,
   param_bitmask_mem_if.slave bus
);

   typedef enum logic {SWEEP, IDLE} state_t;

   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] ptr;
   logic [ADDR_W-1:0] ptr_nxt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              in_range;
   logic              acc_ok;
   logic              rd_req;
   logic              wr_req;
   logic              err_nxt;
   logic [DATA_W-1:0] rd_word;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic              err_q;

   assign in_range = 32'(bus.addr) < DEPTH;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= SWEEP;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         ptr   <= ptr_nxt;
      end
   end

   // clr is only honoured from IDLE, so a request during a sweep never restarts it.
   always_comb begin
      state_nxt = state;
      ptr_nxt   = ptr;
      acc_ok    = 1'b0;
      case (state)
         SWEEP: begin
            ptr_nxt = ptr + 1'b1;
            if (ptr == LAST) begin
               state_nxt = IDLE;
               ptr_nxt   = '0;
            end
         end
         IDLE: begin
            if (bus.clr) begin
               state_nxt = SWEEP;
               ptr_nxt   = '0;
            end else begin
               acc_ok = bus.enb;
            end
         end
         default: begin
            state_nxt = SWEEP;
            ptr_nxt   = '0;
         end
      endcase
   end

   assign rd_req   = acc_ok && !bus.wr;
   assign wr_req   = acc_ok && bus.wr && in_range;
   assign err_nxt  = bus.enb && ((state != IDLE) || bus.clr || !in_range);
   assign rd_word  = in_range ? mem[bus.addr] : '0;
   assign bus.busy = (state == SWEEP);
   assign bus.err  = err_q;

   // The array has no reset; the sweep is what brings it to a known value.
   always_ff @(posedge clk) begin
      if (state == SWEEP) begin
         mem[ptr] <= INIT_VAL;
      end else if (wr_req) begin
         mem[bus.addr] <= (mem[bus.addr] & ~bus.masked) | (bus.data & bus.masked);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         err_q    <= 1'b0;
      end else begin
         s1_valid <= rd_req;
         err_q    <= err_nxt;
         if (rd_req) begin
            s1_data <= rd_word;
         end
      end
   end

   generate
      if (RD_LAT == 1) begin : g_lat1
         assign bus.r_valid = s1_valid;
         assign bus.r_data  = s1_data;
      end else begin : g_lat2
         logic              s2_valid;
         logic [DATA_W-1:0] s2_data;

         // Data only advances on a valid beat so r_data holds between results.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign bus.r_valid = s2_valid;
         assign bus.r_data  = s2_data;
      end
   endgenerate

endmodule

// File: tb/tb_param_bitmask_mem.sv
// Directed bench for param_bitmask_mem: four instances (base, RD_LAT=2, non-zero
// INIT_VAL, DEPTH=6) share one stimulus bus selected by sel.
module tb_param_bitmask_mem;

   logic        clk;
   logic        rst_n;
   logic        rst_d;
   int          sel;
   logic        enb;
   logic        wr;
   logic        clr;
   logic [2:0]  addr;
   logic [31:0] data;
   logic [31:0] masked;
   logic        busy;
   logic        r_valid;
   logic        err;
   logic [31:0] r_data;
   int          n_checks;
   int          n_fail;

   param_bitmask_mem_if #(.DATA_W(32), .ADDR_W(3)) ifa ();
   param_bitmask_mem_if #(.DATA_W(32), .ADDR_W(3)) ifb ();
   param_bitmask_mem_if #(.DATA_W(32), .ADDR_W(3)) ifc ();
   param_bitmask_mem_if #(.DATA_W(32), .ADDR_W(3)) ifd ();

   param_bitmask_mem #(.DATA_W(32), .DEPTH(8), .RD_LAT(1), .INIT_VAL(32'h0))
      dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
   param_bitmask_mem #(.DATA_W(32), .DEPTH(8), .RD_LAT(2), .INIT_VAL(32'h0))
      dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
   param_bitmask_mem #(.DATA_W(32), .DEPTH(8), .RD_LAT(1), .INIT_VAL(32'h12345678))
      dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));
   param_bitmask_mem #(.DATA_W(32), .DEPTH(6), .RD_LAT(1), .INIT_VAL(32'h0))
      dut_d (.clk(clk), .rst_n(rst_d), .bus(ifd));

   assign ifa.enb = enb && (sel == 0);
   assign ifb.enb = enb && (sel == 1);
   assign ifc.enb = enb && (sel == 2);
   assign ifd.enb = enb && (sel == 3);
   assign ifa.clr = clr && (sel == 0);
   assign ifb.clr = clr && (sel == 1);
   assign ifc.clr = clr && (sel == 2);
   assign ifd.clr = clr && (sel == 3);
   assign ifa.wr = wr;
   assign ifb.wr = wr;
   assign ifc.wr = wr;
   assign ifd.wr = wr;
   assign ifa.addr = addr;
   assign ifb.addr = addr;
   assign ifc.addr = addr;
   assign ifd.addr = addr;
   assign ifa.data = data;
   assign ifb.data = data;
   assign ifc.data = data;
   assign ifd.data = data;
   assign ifa.masked = masked;
   assign ifb.masked = masked;
   assign ifc.masked = masked;
   assign ifd.masked = masked;

   always_comb begin
      busy    = 1'b0;
      r_valid = 1'b0;
      err     = 1'b0;
      r_data  = '0;
      case (sel)
         0: begin busy = ifa.busy; r_valid = ifa.r_valid; err = ifa.err; r_data = ifa.r_data; end
         1: begin busy = ifb.busy; r_valid = ifb.r_valid; err = ifb.err; r_data = ifb.r_data; end
         2: begin busy = ifc.busy; r_valid = ifc.r_valid; err = ifc.err; r_data = ifc.r_data; end
         default: begin busy = ifd.busy; r_valid = ifd.r_valid; err = ifd.err; r_data = ifd.r_data; end
      endcase
   end

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Called on a falling edge; returns on the falling edge after the request edge.
   task automatic write_one(input logic [2:0] a, input logic [31:0] d, input logic [31:0] m,
                            output logic e);
      enb = 1'b1; wr = 1'b1; addr = a; data = d; masked = m;
      @(negedge clk);
      e = err;
      enb = 1'b0; wr = 1'b0;
   endtask

   task automatic read_one(input logic [2:0] a, input int lat, output logic [31:0] q,
                           output logic v, output logic e);
      enb = 1'b1; wr = 1'b0; addr = a;
      @(negedge clk);
      e = err;
      enb = 1'b0;
      for (int i = 1; i < lat; i++) @(negedge clk);
      q = r_data;
      v = r_valid;
   endtask

   task automatic test_reset();
      sel = 0;
      @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
      n_checks++; if (r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rvalid: got %b expected 0", r_valid); end
      n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
      n_checks++; if (r_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", r_data); end
      sel = 3;
      #1;
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy_d: got %b expected 1", busy); end
      sel = 0;
   endtask

   task automatic test_reset_sweep();
      int cnt;
      sel = 0;
      cnt = 0;
      rst_n = 1'b1;
      rst_d = 1'b1;
      while (busy && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++; if (cnt != 8) begin n_fail++; $display("[TB] FAIL sweep_len: got %0d expected 8", cnt); end
   endtask

   task automatic test_back_to_back(input int s, input int lat, input logic [31:0] mult);
      logic        exp_v;
      logic [31:0] exp_d;
      sel = s;
      for (int j = 0; j < 8 + lat + 2; j++) begin
         exp_v = (j >= lat) && (j < 8 + lat);
         exp_d = 32'(j - lat) * mult;
         n_checks++;
         if (r_valid !== exp_v) begin
            n_fail++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b expected %b", j, r_valid, exp_v);
         end
         if (exp_v) begin
            n_checks++;
            if (r_data !== exp_d) begin
               n_fail++; $display("[TB] FAIL b2b_rdata[%0d]: got %h expected %h", j, r_data, exp_d);
            end
         end
         if (j < 8) begin
            enb = 1'b1; wr = 1'b0; addr = 3'(j);
         end else begin
            enb = 1'b0;
         end
         @(negedge clk);
      end
      enb = 1'b0;
   endtask

   task automatic test_masked_write();
      logic [31:0] q;
      logic        v, e;
      sel = 0;
      write_one(3'd3, 32'h0000003F, 32'h000003FF, e);
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("[TB] FAIL mw_err: got %b expected 0", e); end
      read_one(3'd3, 1, q, v, e);
      n_checks++; if (q !== 32'h0000003F || v !== 1'b1) begin n_fail++; $display("[TB] FAIL mw_read1: got %h/%b expected 0000003f/1", q, v); end
      write_one(3'd3, 32'hFFFFFF87, 32'hFFE003FF, e);
      read_one(3'd3, 1, q, v, e);
      n_checks++; if (q !== 32'hFFE00387 || v !== 1'b1) begin n_fail++; $display("[TB] FAIL mw_read2: got %h/%b expected ffe00387/1", q, v); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("[TB] FAIL mw_read_err: got %b expected 0", e); end
      @(negedge clk);
      n_checks++; if (r_valid !== 1'b0 || r_data !== 32'hFFE00387) begin n_fail++; $display("[TB] FAIL mw_hold: got %h/%b expected ffe00387/0", r_data, r_valid); end
   endtask

   task automatic test_zero_mask();
      logic [31:0] q, d, m, expv;
      logic        v, e;
      sel = 0;
      write_one(3'd3, 32'hFFFFFFFF, 32'h0, e);
      read_one(3'd3, 1, q, v, e);
      n_checks++; if (q !== 32'hFFE00387) begin n_fail++; $display("[TB] FAIL zero_mask: got %h expected ffe00387", q); end
      d = $urandom;
      m = $urandom;
      expv = (32'h0 & ~m) | (d & m);
      write_one(3'd7, d, m, e);
      read_one(3'd7, 1, q, v, e);
      n_checks++; if (q !== expv || v !== 1'b1) begin n_fail++; $display("[TB] FAIL rand_mask: got %h/%b expected %h/1", q, v, expv); end
   endtask

   task automatic test_rd_lat2();
      logic e;
      sel = 1;
      for (int i = 0; i < 8; i++) write_one(3'(i), 32'(i) * 32'h11111111, 32'hFFFFFFFF, e);
      @(negedge clk);
      test_back_to_back(1, 2, 32'h11111111);
   endtask

   task automatic test_clear();
      logic [31:0] q;
      logic        v, e;
      int          cnt;
      sel = 2;
      for (int i = 0; i < 8; i++) write_one(3'(i), 32'hA5A5A5A5, 32'hFFFFFFFF, e);
      read_one(3'd0, 1, q, v, e);
      n_checks++; if (q !== 32'hA5A5A5A5) begin n_fail++; $display("[TB] FAIL fill_read: got %h expected a5a5a5a5", q); end
      cnt = 0;
      clr = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         clr = 1'b0; enb = 1'b0; wr = 1'b0;
         if (busy) cnt++;
         if (k == 3) begin
            n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_busy_err: got %b expected 0", err); end
         end
         if (k == 6) begin
            n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL busy_write_err: got %b expected 1", err); end
         end
         if (k == 2) clr = 1'b1;
         if (k == 5) begin enb = 1'b1; wr = 1'b1; addr = 3'd0; data = 32'h0; masked = 32'hFFFFFFFF; end
      end
      n_checks++; if (cnt != 8) begin n_fail++; $display("[TB] FAIL clr_sweep_len: got %0d expected 8", cnt); end
      for (int i = 0; i < 8; i++) begin
         read_one(3'(i), 1, q, v, e);
         n_checks++; if (q !== 32'h12345678 || v !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_read[%0d]: got %h/%b expected 12345678/1", i, q, v); end
      end
      clr = 1'b1; enb = 1'b1; wr = 1'b0; addr = 3'd1;
      @(negedge clk);
      clr = 1'b0; enb = 1'b0;
      n_checks++; if (err !== 1'b1 || r_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_vs_access: got err=%b rv=%b expected err=1 rv=0", err, r_valid); end
      cnt = 0;
      while (busy && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++; if (cnt != 8) begin n_fail++; $display("[TB] FAIL clr2_sweep_len: got %0d expected 8", cnt); end
   endtask

   task automatic test_out_of_range();
      logic [31:0] q;
      logic        v, e;
      sel = 3;
      write_one(3'd5, 32'hDEADBEEF, 32'hFFFFFFFF, e);
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_inrange_err: got %b expected 0", e); end
      write_one(3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, e);
      n_checks++; if (e !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_write_err: got %b expected 1", e); end
      read_one(3'd5, 1, q, v, e);
      n_checks++; if (q !== 32'hDEADBEEF || v !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_read5: got %h/%b expected deadbeef/1", q, v); end
      read_one(3'd7, 1, q, v, e);
      n_checks++; if (q !== 32'h0 || v !== 1'b1 || e !== 1'b1) begin n_fail++; $display("[TB] FAIL oor_read7: got %h/%b/%b expected 00000000/1/1", q, v, e); end
      read_one(3'd5, 1, q, v, e);
      n_checks++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL oor_reread5: got %h expected deadbeef", q); end
   endtask

   task automatic test_reset_mid_sweep();
      logic [31:0] q;
      logic        v, e;
      int          cnt;
      sel = 3;
      rst_d = 1'b0;
      @(negedge clk);
      n_checks++; if (r_data !== 32'h0 || busy !== 1'b1) begin n_fail++; $display("[TB] FAIL d_reset: got %h/%b expected 00000000/1", r_data, busy); end
      rst_d = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL d_midsweep_busy: got %b expected 1", busy); end
      rst_d = 1'b0;
      @(negedge clk);
      rst_d = 1'b1;
      cnt = 0;
      while (busy && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      n_checks++; if (cnt != 6) begin n_fail++; $display("[TB] FAIL d_restart_len: got %0d expected 6", cnt); end
      read_one(3'd5, 1, q, v, e);
      n_checks++; if (q !== 32'h0 || v !== 1'b1) begin n_fail++; $display("[TB] FAIL d_swept5: got %h/%b expected 00000000/1", q, v); end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      sel      = 0;
      rst_n    = 1'b0;
      rst_d    = 1'b0;
      enb      = 1'b0;
      wr       = 1'b0;
      clr      = 1'b0;
      addr     = '0;
      data     = '0;
      masked   = '0;
      $display("[TB] starting param_bitmask_mem bench");
      test_reset();
      test_reset_sweep();
      test_back_to_back(0, 1, 32'h0);
      test_masked_write();
      test_zero_mask();
      test_rd_lat2();
      test_clear();
      test_out_of_range();
      test_reset_mid_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
